// File: rtl/fwd_regfile_dual_if.sv
// Decode-stage bus for fwd_regfile_dual: pipeline inputs plus forwarded operands,
// raw register-file reads and load-use stall status.
interface fwd_regfile_dual_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 16
) ();
  logic [3:0]        D_icode;
  logic [DATA_W-1:0] D_valP;
  logic [REG_AW-1:0] d_srcA;
  logic [REG_AW-1:0] d_srcB;
  logic [DATA_W-1:0] e_valE;
  logic [REG_AW-1:0] e_dstE;
  logic [3:0]        E_icode;
  logic [REG_AW-1:0] E_dstM;
  logic [DATA_W-1:0] M_valE;
  logic [REG_AW-1:0] M_dstE;
  logic [DATA_W-1:0] m_valM;
  logic [REG_AW-1:0] M_dstM;
  logic [DATA_W-1:0] W_valE;
  logic [REG_AW-1:0] W_dstE;
  logic [DATA_W-1:0] W_valM;
  logic [REG_AW-1:0] W_dstM;
  logic [DATA_W-1:0] d_valA;
  logic [DATA_W-1:0] d_valB;
  logic [DATA_W-1:0] d_rvalA;
  logic [DATA_W-1:0] d_rvalB;
  logic              stall_lu;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output D_icode, D_valP, d_srcA, d_srcB, e_valE, e_dstE, E_icode, E_dstM,
           M_valE, M_dstE, m_valM, M_dstM, W_valE, W_dstE, W_valM, W_dstM,
    input  d_valA, d_valB, d_rvalA, d_rvalB, stall_lu, stall_cnt
  );

  modport slave (
    input  D_icode, D_valP, d_srcA, d_srcB, e_valE, e_dstE, E_icode, E_dstM,
           M_valE, M_dstE, m_valM, M_dstM, W_valE, W_dstE, W_valM, W_dstM,
    output d_valA, d_valB, d_rvalA, d_rvalB, stall_lu, stall_cnt
  );
endinterface

// File: rtl/fwd_regfile_dual.sv
// Y86-64 decode-stage register file with dual-operand forwarding, load-use
// hazard detection and a saturating stall counter.
module fwd_regfile_dual #(
  parameter int unsigned       DATA_W      = 64,
  parameter int unsigned       REG_AW      = 4,
  parameter int unsigned       NREG        = 15,
  parameter int unsigned       RSP_ID      = 4,
  parameter logic [DATA_W-1:0] RSP_INIT    = '0,
  parameter bit                VALP_SEL_EN = 1'b1,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  fwd_regfile_dual_if.slave bus
);

  localparam int unsigned       IDX_W    = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [REG_AW-1:0] RNONE    = '1;
  localparam logic [3:0]        I_JXX    = 4'h7;
  localparam logic [3:0]        I_CALL   = 4'h8;
  localparam logic [3:0]        I_MRMOVQ = 4'h5;
  localparam logic [3:0]        I_POPQ   = 4'hB;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] rval_a;
  logic [DATA_W-1:0] rval_b;
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;
  logic              lu_c;

  // RNONE and any ID beyond the implemented registers address nothing
  function automatic logic id_ok(input logic [REG_AW-1:0] id);
    return 32'(id) < NREG;
  endfunction

  // Next-state: write-back port M is applied after E so it wins on equal IDs
  always_comb begin
    regs_d = regs_q;
    if (id_ok(bus.W_dstE)) regs_d[IDX_W'(bus.W_dstE)] = bus.W_valE;
    if (id_ok(bus.W_dstM)) regs_d[IDX_W'(bus.W_dstM)] = bus.W_valM;
    cnt_d = cnt_q;
    if (lu_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[IDX_W'(i)] <= (i == RSP_ID) ? RSP_INIT : '0;
      end
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rval_a = '0;
    rval_b = '0;
    if (id_ok(bus.d_srcA)) rval_a = regs_q[IDX_W'(bus.d_srcA)];
    if (id_ok(bus.d_srcB)) rval_b = regs_q[IDX_W'(bus.d_srcB)];
  end

  // Sources are layered oldest-first so the youngest matching stage overrides
  always_comb begin
    val_a = rval_a;
    val_b = rval_b;
    if (bus.W_dstE == bus.d_srcA) val_a = bus.W_valE;
    if (bus.W_dstM == bus.d_srcA) val_a = bus.W_valM;
    if (bus.M_dstE == bus.d_srcA) val_a = bus.M_valE;
    if (bus.M_dstM == bus.d_srcA) val_a = bus.m_valM;
    if (bus.e_dstE == bus.d_srcA) val_a = bus.e_valE;
    if (bus.d_srcA == RNONE)      val_a = '0;
    if (VALP_SEL_EN && ((bus.D_icode == I_CALL) || (bus.D_icode == I_JXX))) val_a = bus.D_valP;

    if (bus.W_dstE == bus.d_srcB) val_b = bus.W_valE;
    if (bus.W_dstM == bus.d_srcB) val_b = bus.W_valM;
    if (bus.M_dstE == bus.d_srcB) val_b = bus.M_valE;
    if (bus.M_dstM == bus.d_srcB) val_b = bus.m_valM;
    if (bus.e_dstE == bus.d_srcB) val_b = bus.e_valE;
    if (bus.d_srcB == RNONE)      val_b = '0;
  end

  always_comb begin
    lu_c = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
           (bus.E_dstM != RNONE) &&
           ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
  end

  assign bus.d_valA    = val_a;
  assign bus.d_valB    = val_b;
  assign bus.d_rvalA   = rval_a;
  assign bus.d_rvalB   = rval_b;
  assign bus.stall_lu  = lu_c;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_regfile_dual.sv
// Directed and randomized checks of fwd_regfile_dual against a behavioural model;
// a second instance with a 2-bit counter exercises saturation.
module tb_fwd_regfile_dual;

  localparam logic [63:0] RSP_VAL = 64'h0000_0000_0000_1000;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fwd_regfile_dual_if #(.DATA_W(64), .REG_AW(4), .CNT_W(16)) bus ();
  fwd_regfile_dual_if #(.DATA_W(64), .REG_AW(4), .CNT_W(2))  bus2 ();

  fwd_regfile_dual #(.RSP_INIT(RSP_VAL), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  fwd_regfile_dual #(.RSP_INIT(RSP_VAL), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.D_icode = bus.D_icode;
  assign bus2.D_valP  = bus.D_valP;
  assign bus2.d_srcA  = bus.d_srcA;
  assign bus2.d_srcB  = bus.d_srcB;
  assign bus2.e_valE  = bus.e_valE;
  assign bus2.e_dstE  = bus.e_dstE;
  assign bus2.E_icode = bus.E_icode;
  assign bus2.E_dstM  = bus.E_dstM;
  assign bus2.M_valE  = bus.M_valE;
  assign bus2.M_dstE  = bus.M_dstE;
  assign bus2.m_valM  = bus.m_valM;
  assign bus2.M_dstM  = bus.M_dstM;
  assign bus2.W_valE  = bus.W_valE;
  assign bus2.W_dstE  = bus.W_dstE;
  assign bus2.W_valM  = bus.W_valM;
  assign bus2.W_dstM  = bus.W_dstM;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference state
  logic [63:0] mregs [15];
  int unsigned mcnt16;
  int unsigned mcnt2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [3:0] src);
    return (src < 4'd15) ? mregs[src] : 64'd0;
  endfunction

  function automatic logic [63:0] m_fwd(input bit is_a, input logic [3:0] src);
    if (is_a && (bus.D_icode == 4'd7 || bus.D_icode == 4'd8)) return bus.D_valP;
    if (src == 4'hF)        return 64'd0;
    if (bus.e_dstE == src)  return bus.e_valE;
    if (bus.M_dstM == src)  return bus.m_valM;
    if (bus.M_dstE == src)  return bus.M_valE;
    if (bus.W_dstM == src)  return bus.W_valM;
    if (bus.W_dstE == src)  return bus.W_valE;
    return m_read(src);
  endfunction

  function automatic logic m_stall();
    return (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) && bus.E_dstM != 4'hF &&
           (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 15; i++) mregs[i] = (i == 4) ? RSP_VAL : 64'd0;
      mcnt16 = 0;
      mcnt2  = 0;
    end else begin
      if (bus.W_dstE < 4'd15) mregs[bus.W_dstE] = bus.W_valE;
      if (bus.W_dstM < 4'd15) mregs[bus.W_dstM] = bus.W_valM;
      if (m_stall()) begin
        if (mcnt16 < 65535) mcnt16++;
        if (mcnt2 < 3) mcnt2++;
      end
    end
  endtask

  task automatic check_model();
    chk("m_valA",  bus.d_valA,  m_fwd(1'b1, bus.d_srcA));
    chk("m_valB",  bus.d_valB,  m_fwd(1'b0, bus.d_srcB));
    chk("m_rvalA", bus.d_rvalA, m_read(bus.d_srcA));
    chk("m_rvalB", bus.d_rvalB, m_read(bus.d_srcB));
    chk("m_stall", 64'(bus.stall_lu), 64'(m_stall()));
    chk("m_cnt16", 64'(bus.stall_cnt), 64'(mcnt16));
    chk("m_cnt2",  64'(bus2.stall_cnt), 64'(mcnt2));
  endtask

  // One clock: model check before the edge, model update at the edge
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.D_icode = 4'h0; bus.D_valP = '0;
    bus.d_srcA  = 4'hF; bus.d_srcB = 4'hF;
    bus.e_valE  = '0;   bus.e_dstE = 4'hF;
    bus.E_icode = 4'h0; bus.E_dstM = 4'hF;
    bus.M_valE  = '0;   bus.M_dstE = 4'hF;
    bus.m_valM  = '0;   bus.M_dstM = 4'hF;
    bus.W_valE  = '0;   bus.W_dstE = 4'hF;
    bus.W_valM  = '0;   bus.W_dstM = 4'hF;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;

    // Reset state
    bus.d_srcA = 4'd1; bus.d_srcB = 4'd4;
    #2;
    chk("rst_rvalA", bus.d_rvalA, 64'd0);
    chk("rst_rsp",   bus.d_rvalB, RSP_VAL);
    chk("rst_cnt",   64'(bus.stall_cnt), 64'd0);
    tick();

    // Call selects valP, then W_dstM beats W_dstE
    idle();
    bus.D_icode = 4'h8; bus.D_valP = 64'd125; bus.d_srcA = 4'd7;
    bus.W_dstE = 4'd7; bus.W_valE = 64'd14; bus.W_dstM = 4'd7; bus.W_valM = 64'd30;
    bus.e_dstE = 4'd12;
    #2;
    chk("call_valp", bus.d_valA, 64'd125);
    bus.D_icode = 4'h6;
    #2;
    chk("w_m_over_e", bus.d_valA, 64'd30);
    idle();
    tick();

    // Stage priority
    bus.d_srcA = 4'd5; bus.d_srcB = 4'd5;
    bus.e_dstE = 4'd5; bus.e_valE = 64'd7;
    bus.M_dstM = 4'd5; bus.m_valM = 64'd2;
    bus.M_dstE = 4'd5; bus.M_valE = 64'd10;
    #2;
    chk("pri_e_a", bus.d_valA, 64'd7);
    chk("pri_e_b", bus.d_valB, 64'd7);
    bus.e_dstE = 4'hF;
    #2;
    chk("pri_mm_a", bus.d_valA, 64'd2);
    chk("pri_mm_b", bus.d_valB, 64'd2);
    bus.M_dstM = 4'hF;
    #2;
    chk("pri_me_a", bus.d_valA, 64'd10);
    chk("pri_me_b", bus.d_valB, 64'd10);
    tick();

    // Write-back, M port wins on equal destinations
    idle();
    bus.W_dstE = 4'd3; bus.W_valE = 64'd14; bus.W_dstM = 4'd3; bus.W_valM = 64'd30;
    tick();
    idle();
    bus.d_srcA = 4'd3;
    #2;
    chk("wb_same_id", bus.d_rvalA, 64'd30);
    bus.W_dstM = 4'd2; bus.W_valM = 64'd9;
    tick();
    idle();
    bus.d_srcA = 4'd2; bus.d_srcB = 4'd3;
    #2;
    chk("wb_reg2", bus.d_rvalA, 64'd9);
    chk("wb_reg3", bus.d_rvalB, 64'd30);
    tick();

    // Reset discards a simultaneous write and clears the counter
    idle();
    bus.W_dstE = 4'd1; bus.W_valE = 64'd55;
    bus.E_icode = 4'h5; bus.E_dstM = 4'd6; bus.d_srcB = 4'd6;
    tick();
    idle();
    bus.d_srcA = 4'd1;
    #2;
    chk("pre_rst_r1", bus.d_rvalA, 64'd55);
    chk("pre_rst_cnt", 64'(bus.stall_cnt), 64'd1);
    bus.W_dstE = 4'd1; bus.W_valE = 64'd77;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    bus.d_srcA = 4'd1; bus.d_srcB = 4'd4;
    #2;
    chk("post_rst_r1",  bus.d_rvalA, 64'd0);
    chk("post_rst_rsp", bus.d_rvalB, RSP_VAL);
    chk("post_rst_cnt", 64'(bus.stall_cnt), 64'd0);
    tick();

    // Load-use detection and counting
    idle();
    bus.E_icode = 4'h5; bus.E_dstM = 4'd6; bus.d_srcB = 4'd6;
    #2;
    chk("lu_set", 64'(bus.stall_lu), 64'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("lu_cnt3", 64'(bus.stall_cnt), 64'd3);
    bus.E_icode = 4'h2;
    #2;
    chk("lu_clr", 64'(bus.stall_lu), 64'd0);
    tick();
    chk("lu_hold", 64'(bus.stall_cnt), 64'd3);
    bus.E_icode = 4'hB; bus.E_dstM = 4'hF; bus.d_srcB = 4'hF;
    #2;
    chk("lu_rnone", 64'(bus.stall_lu), 64'd0);
    tick();

    // 2-bit counter saturation
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.E_icode = 4'hB; bus.E_dstM = 4'd9; bus.d_srcA = 4'd9;
    chk("sat_0", 64'(bus2.stall_cnt), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("sat_%0d", i), 64'(bus2.stall_cnt), 64'((i < 3) ? i : 3));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.D_icode = 4'($urandom_range(0, 15));
      bus.D_valP  = {$urandom, $urandom};
      bus.d_srcA  = 4'($urandom_range(0, 15));
      bus.d_srcB  = 4'($urandom_range(0, 15));
      bus.e_valE  = {$urandom, $urandom};
      bus.e_dstE  = 4'($urandom_range(0, 15));
      bus.E_icode = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 0) ? 4'h5 : 4'hB)
                                                 : 4'($urandom_range(0, 15));
      bus.E_dstM  = 4'($urandom_range(0, 15));
      bus.M_valE  = {$urandom, $urandom};
      bus.M_dstE  = 4'($urandom_range(0, 15));
      bus.m_valM  = {$urandom, $urandom};
      bus.M_dstM  = 4'($urandom_range(0, 15));
      bus.W_valE  = {$urandom, $urandom};
      bus.W_dstE  = 4'($urandom_range(0, 15));
      bus.W_valM  = {$urandom, $urandom};
      bus.W_dstM  = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_regfile_dual.md
Name: fwd_regfile_dual

Overview:
- Parametrised successor to the single-operand forward-select logic in the Y86-64 pipeline.
- Combines the architectural register file (synchronous write-back from W) with forwarding for both decode operands, valA and valB.
- Adds load-use hazard detection and a saturating stall counter.
- Sits in the Decode stage; its outputs feed the D/E pipeline register and the pipeline control logic.

Parameters:
- DATA_W, 64, register/data width in bits.
- REG_AW, 4, register-ID width; ID all-ones (RNONE) means "no register".
- NREG, 15, number of architectural registers (IDs 0..NREG-1, NREG <= 2**REG_AW - 1).
- RSP_ID, 4, ID of the stack pointer.
- RSP_INIT, 0, reset value of the stack-pointer register.
- VALP_SEL_EN, 1, 1 = valA takes D_valP for call (8) / jXX (7); 0 = never.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- D_icode  in  4  decode-stage icode
- D_valP  in  DATA_W  decode-stage valP
- d_srcA, d_srcB  in  REG_AW  decode source IDs
- e_valE, e_dstE  in  DATA_W / REG_AW  execute-stage result and destination
- E_icode, E_dstM  in  4 / REG_AW  E-register icode and load destination
- M_valE, M_dstE  in  DATA_W / REG_AW  memory-stage valE and destination
- m_valM, M_dstM  in  DATA_W / REG_AW  memory read data and destination
- W_valE, W_dstE, W_valM, W_dstM  in  DATA_W / REG_AW  write-back values and destinations
- d_valA, d_valB  out  DATA_W  forwarded operands, combinational
- d_rvalA, d_rvalB  out  DATA_W  raw register-file reads, combinational
- stall_lu  out  1  load-use hazard, combinational
- stall_cnt  out  CNT_W  registered count of cycles with stall_lu=1

Behaviour:
- Reset (rst=1 at posedge):
  - All registers clear to 0, except RSP_ID, which loads RSP_INIT.
  - stall_cnt clears to 0.
  - Reset wins over any simultaneous write-back or count.
- Write-back (posedge, rst=0):
  - If W_dstE != RNONE, reg[W_dstE] <= W_valE.
  - If W_dstM != RNONE, reg[W_dstM] <= W_valM.
  - If W_dstE == W_dstM != RNONE, W_valM wins (popq %rsp semantics).
  - IDs >= NREG other than RNONE are ignored (no write).
- Raw read:
  - d_rvalX = reg[d_srcX].
  - Returns 0 if d_srcX is RNONE or >= NREG.
  - Returns the pre-edge value; there is no internal write-through, because forwarding covers W.
- d_valA priority, first match wins:
  1. VALP_SEL_EN and D_icode in {7,8} -> D_valP
  2. d_srcA == RNONE -> 0
  3. e_dstE -> e_valE
  4. M_dstM -> m_valM
  5. M_dstE -> M_valE
  6. W_dstM -> W_valM
  7. W_dstE -> W_valE
  8. otherwise d_rvalA
- d_valB: same order, without step 1.
- RNONE never matches any dst. Not-taken cmov arrives upstream with e_dstE = RNONE; nothing special is done here.
- Load-use: stall_lu = 1 when all of the following hold:
  - E_icode is mrmovq (5) or popq (B),
  - E_dstM != RNONE,
  - E_dstM == d_srcA or E_dstM == d_srcB.
- stall_lu is independent of D_icode valP selection.
- stall_cnt:
  - Increments at posedge when stall_lu=1.
  - Saturates at 2**CNT_W-1 (no wrap).
  - Holds otherwise.
- Latency:
  - Forwarded outputs and stall_lu: 0 cycles, combinational.
  - A write is visible on d_rvalX the cycle after its edge.
- Widths: all data paths DATA_W, no arithmetic except the counter.

Test Plan:
1. Call valP: D_icode=8, D_valP=125, d_srcA=7, W_dstE=W_dstM=7 (W_valE=14, W_valM=30), e_dstE=12 -> d_valA=125. Then D_icode=6 -> d_valA=30 (W_dstM beats W_dstE).
2. Priority: d_srcA=d_srcB=5, e_dstE=5/e_valE=7, M_dstM=5/m_valM=2, M_dstE=5/M_valE=10 -> d_valA=d_valB=7. Set e_dstE=F -> 2. Set M_dstM=F -> 10.
3. Write-back:
   - W_dstE=3/W_valE=14 and W_dstM=3/W_valM=30 for one edge, then W dsts=F -> d_rvalA(src 3)=30 next cycle.
   - W_dstE=F, W_dstM=2/W_valM=9 -> reg2=9; reg3 unchanged.
4. Reset: write reg1=55, then assert rst for one edge -> d_rvalA(src 1)=0, d_rvalB(src 4)=RSP_INIT, stall_cnt=0. A W write on the reset edge is discarded.
5. Load-use: E_icode=5, E_dstM=6, d_srcB=6 -> stall_lu=1; hold 3 cycles -> stall_cnt=3. E_icode=2 -> stall_lu=0, count holds at 3. E_dstM=F with E_icode=B -> stall_lu=0.
6. Saturation with CNT_W=2: hold stall_lu=1 for 5 edges -> stall_cnt = 0,1,2,3,3,3.
